mul_accum: RTL

Downstream consumer of the 5x5 pipelined multiplier. Tracks which multiplier issue cycles carried real operands with a valid delay line matched to the multiplier latency. Sums each group of COUNT valid products into one accumulated result with a single-cycle completion pulse and an overflow flag. The multiplier has no valid handshake of its own, so this block supplies alignment and framing for the multiply-accumulate datapath.

---
 rtl/mul_accum_if.sv | 35 +++
 rtl/mul_accum.sv | 137 +++++++++++++
 2 files changed

// File: rtl/mul_accum_if.sv
// Bus between the multiplier-side producer and the mul_accum consumer.
// The producer drives issue/flush and the multiplier result; the
// accumulator returns the completed group sum, its flags and busy.
interface mul_accum_if #(
  parameter int PROD_W = 10,
  parameter int ACC_W  = 12
);
  logic              op_valid;
  logic              clr;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  acc_out;
  logic              acc_valid;
  logic              ovf;
  logic              busy;

  modport master (
    output op_valid,
    output clr,
    output prod,
    input  acc_out,
    input  acc_valid,
    input  ovf,
    input  busy
  );

  modport slave (
    input  op_valid,
    input  clr,
    input  prod,
    output acc_out,
    output acc_valid,
    output ovf,
    output busy
  );
endinterface

// File: rtl/mul_accum.sv
// Multiply-accumulate framing for the pipelined 5x5 multiplier.
// A valid delay line matched to the multiplier latency marks the cycles in
// which the multiplier result is real; every COUNT such products are summed
// into one result with a one-cycle completion pulse and a carry flag.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no partial sum; count = 0; acc = 0
// ACCUM | partial sum held in acc; count of products taken is 1..COUNT-1
module mul_accum #(
  parameter int PROD_W  = 10,
  parameter int MUL_LAT = 2,
  parameter int COUNT   = 4,
  parameter int ACC_W   = 12
) (
  input  logic        clk,
  input  logic        rst,
  mul_accum_if.slave  bus
);

  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [MUL_LAT-1:0] dly_q, dly_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               sticky_q, sticky_d;
  logic [ACC_W-1:0]   acc_out_q, acc_out_d;
  logic               acc_valid_q, acc_valid_d;
  logic               ovf_q, ovf_d;

  logic               pv;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W:0]     sum;

  // The last delay stage lines up with the cycle the multiplier result is real.
  assign pv       = dly_q[MUL_LAT-1];
  assign prod_ext = ACC_W'(bus.prod);
  // One extra bit catches the carry out of the accumulator width.
  assign sum      = {1'b0, acc_q} + {1'b0, prod_ext};

  // Next-state: delay-line shift, group accumulation, completion and flush.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    acc_out_d   = acc_out_q;
    ovf_d       = ovf_q;
    acc_valid_d = 1'b0;

    dly_d[0] = bus.op_valid;
    for (int i = 1; i < MUL_LAT; i++) begin
      dly_d[i] = dly_q[i-1];
    end

    if (bus.clr) begin
      // Flush drops in-flight operands too, including one issued this cycle
      // and a product that would have completed this cycle.
      dly_d    = '0;
      state_d  = IDLE;
      cnt_d    = '0;
      acc_d    = '0;
      sticky_d = 1'b0;
    end else if (pv) begin
      case (state_q)
        IDLE: begin
          if (COUNT == 1) begin
            acc_out_d   = prod_ext;
            ovf_d       = 1'b0;
            acc_valid_d = 1'b1;
          end else begin
            acc_d   = prod_ext;
            cnt_d   = CNT_W'(1);
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          if (cnt_q == CNT_LAST) begin
            acc_out_d   = sum[ACC_W-1:0];
            ovf_d       = sticky_q | sum[ACC_W];
            acc_valid_d = 1'b1;
            cnt_d       = '0;
            acc_d       = '0;
            sticky_d    = 1'b0;
            state_d     = IDLE;
          end else begin
            acc_d    = sum[ACC_W-1:0];
            cnt_d    = cnt_q + CNT_W'(1);
            sticky_d = sticky_q | sum[ACC_W];
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          acc_d   = '0;
        end
      endcase
    end
  end

  // State, delay line and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dly_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      acc_out_q   <= '0;
      acc_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dly_q       <= dly_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      acc_out_q   <= acc_out_d;
      acc_valid_q <= acc_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.acc_out   = acc_out_q;
  assign bus.acc_valid = acc_valid_q;
  assign bus.ovf       = ovf_q;
  // Busy covers both a partial group and products still inside the multiplier.
  assign bus.busy      = (state_q == ACCUM) || (|dly_q);

endmodule
